// File: rtl/washer_plant_model.sv
// washer_plant_model: cycle-based washer plant turning actuator commands into sensor feedback.
// Optional leak-injection path is compiled in when WASHER_PLANT_LEAK_EN is defined.
module washer_plant_model #(
  parameter int LEVEL_W      = 8,
  parameter int LEVEL_MAX    = 255,
  parameter int FULL_LEVEL   = 200,
  parameter int FILL_STEP    = 4,
  parameter int DRAIN_STEP   = 8,
  parameter int MOIST_MAX    = 16,
  parameter int SPINUP_STEPS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  input  logic               water_fill,
  input  logic               motor_wash,
  input  logic               motor_spin,
  input  logic               drain,
  input  logic               err_clr,
`ifdef WASHER_PLANT_LEAK_EN
  input  logic               leak_inject,
`endif
  output logic               water_full,
  output logic               drained,
  output logic               dry_sensor,
  output logic [LEVEL_W-1:0] level,
  output logic [1:0]         spin_state,
  output logic [3:0]         err
);

  localparam int MOIST_W   = $clog2(MOIST_MAX + 1);
  localparam int CNT_W     = (SPINUP_STEPS > 1) ? $clog2(SPINUP_STEPS) : 1;
  localparam int UNIT      = 1;
  localparam int RAMP_LAST = SPINUP_STEPS - 1;

  localparam logic [LEVEL_W:0]   LVL_MAX_X = LEVEL_MAX[LEVEL_W:0];
  localparam logic [LEVEL_W:0]   FILL_X    = FILL_STEP[LEVEL_W:0];
  localparam logic [LEVEL_W:0]   DRAIN_X   = DRAIN_STEP[LEVEL_W:0];
  localparam logic [LEVEL_W:0]   ONE_X     = UNIT[LEVEL_W:0];
  localparam logic [LEVEL_W-1:0] MAX_C     = LEVEL_MAX[LEVEL_W-1:0];
  localparam logic [LEVEL_W-1:0] FULL_C    = FULL_LEVEL[LEVEL_W-1:0];
  localparam logic [MOIST_W-1:0] MOIST_C   = MOIST_MAX[MOIST_W-1:0];
  localparam logic [MOIST_W-1:0] MOIST_ONE = UNIT[MOIST_W-1:0];
  localparam logic [CNT_W-1:0]   CNT_ONE   = UNIT[CNT_W-1:0];
  localparam logic [CNT_W-1:0]   CNT_LAST  = RAMP_LAST[CNT_W-1:0];

  typedef enum logic [1:0] {
    SPIN_STOP     = 2'b00,
    SPIN_RAMP     = 2'b01,
    SPIN_AT_SPEED = 2'b10
  } spin_t;

  spin_t              spin_q, spin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [MOIST_W-1:0] moist_q, moist_d;
  logic [3:0]         err_q, err_d, new_err;
  logic [LEVEL_W:0]   level_x, sum_x, dec_x;
  logic               fill_only, drain_only, conflict, leak, leak_req;

`ifdef WASHER_PLANT_LEAK_EN
  assign leak_req = leak_inject;
`else
  assign leak_req = 1'b0;
`endif

  assign fill_only  = water_fill & ~drain;
  assign drain_only = drain & ~water_fill;
  assign conflict   = water_fill & drain;
  // A leak only removes water when the fill valve is closed; it is flagged either way.
  assign leak       = leak_req & ~water_fill;

  always_comb begin
    level_x = {1'b0, level_q};
    sum_x   = level_x + FILL_X;
    dec_x   = '0;
    level_d = level_q;
    if (fill_only) begin
      level_d = (sum_x > LVL_MAX_X) ? MAX_C : sum_x[LEVEL_W-1:0];
    end else begin
      if (drain_only) dec_x = dec_x + DRAIN_X;
      if (leak)       dec_x = dec_x + ONE_X;
      level_d = (dec_x >= level_x) ? '0 : LEVEL_W'(level_x - dec_x);
    end
  end

  // Washing re-soaks the clothes; drying only happens at full speed in an empty drum.
  always_comb begin
    moist_d = moist_q;
    if (motor_wash && (level_q != '0)) begin
      moist_d = MOIST_C;
    end else if ((spin_q == SPIN_AT_SPEED) && (level_q == '0) && (moist_q != '0)) begin
      moist_d = moist_q - MOIST_ONE;
    end
  end

  always_comb begin
    spin_d = spin_q;
    cnt_d  = cnt_q;
    case (spin_q)
      SPIN_STOP: begin
        if (motor_spin) begin
          spin_d = SPIN_RAMP;
          cnt_d  = '0;
        end
      end
      SPIN_RAMP: begin
        if (!motor_spin)           spin_d = SPIN_STOP;
        else if (cnt_q == CNT_LAST) spin_d = SPIN_AT_SPEED;
        else                        cnt_d  = cnt_q + CNT_ONE;
      end
      SPIN_AT_SPEED: begin
        if (!motor_spin) spin_d = SPIN_STOP;
      end
      default: spin_d = SPIN_STOP;
    endcase
  end

  // Clear applies on any cycle, but a bit raised on the same step survives it.
  always_comb begin
    new_err    = 4'b0000;
    new_err[0] = conflict;
    new_err[1] = motor_spin & (level_q != '0);
    new_err[2] = fill_only & (level_q == MAX_C);
    new_err[3] = leak_req;
    err_d      = (err_clr ? 4'b0000 : err_q) | (step_en ? new_err : 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      moist_q <= '0;
      cnt_q   <= '0;
      spin_q  <= SPIN_STOP;
      err_q   <= 4'b0000;
    end else begin
      if (step_en) begin
        level_q <= level_d;
        moist_q <= moist_d;
        cnt_q   <= cnt_d;
        spin_q  <= spin_d;
      end
      err_q <= err_d;
    end
  end

  assign water_full = (level_q >= FULL_C);
  assign drained    = (level_q == '0);
  assign dry_sensor = (moist_q == '0);
  assign level      = level_q;
  assign spin_state = spin_q;
  assign err        = err_q;

endmodule

// File: tb/tb_washer_plant_model.sv
// tb_washer_plant_model: directed plant scenarios plus random command bursts, every step
// compared against an integer reference of the plant (spin phase derived from run length).
module tb_washer_plant_model;

  localparam int LEVEL_MAX    = 255;
  localparam int FULL_LEVEL   = 200;
  localparam int FILL_STEP    = 4;
  localparam int DRAIN_STEP   = 8;
  localparam int MOIST_MAX    = 16;
  localparam int SPINUP_STEPS = 4;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic       clk = 1'b0;
  logic       rst, step_en, water_fill, motor_wash, motor_spin, drain, err_clr, leak_inject;
  logic       water_full, drained, dry_sensor;
  logic [7:0] level;
  logic [1:0] spin_state;
  logic [3:0] err;

  int         total = 0;
  int         bad   = 0;
  int         m_level, m_moist, m_spin_run;
  logic [3:0] m_err;

  always #5 clk = ~clk;

  washer_plant_model dut (
    .clk        (clk),
    .rst        (rst),
    .step_en    (step_en),
    .water_fill (water_fill),
    .motor_wash (motor_wash),
    .motor_spin (motor_spin),
    .drain      (drain),
    .err_clr    (err_clr),
`ifdef WASHER_PLANT_LEAK_EN
    .leak_inject(leak_inject),
`endif
    .water_full (water_full),
    .drained    (drained),
    .dry_sensor (dry_sensor),
    .level      (level),
    .spin_state (spin_state),
    .err        (err)
  );

  // Spin phase follows from how many consecutive steps the spin command has been held.
  function automatic int spinExp(input int run);
    if (run == 0) return 0;
    if (run <= SPINUP_STEPS) return 1;
    return 2;
  endfunction

  task automatic applyStimulus(input bit se, input bit wf, input bit mw, input bit ms,
                               input bit dr, input bit ec, input bit r);
    step_en     = se;
    water_fill  = wf;
    motor_wash  = mw;
    motor_spin  = ms;
    drain       = dr;
    err_clr     = ec;
    rst         = r;
    leak_inject = 1'b0;
  endtask

  task automatic modelUpdate();
    int         old_level, old_spin, nxt;
    logic [3:0] raised;
    bit         leak_now;
    if (rst) begin
      m_level    = 0;
      m_moist    = 0;
      m_spin_run = 0;
      m_err      = 4'b0000;
      return;
    end
    raised = 4'b0000;
    if (step_en) begin
      old_level = m_level;
      old_spin  = spinExp(m_spin_run);
      leak_now  = leak_inject && !water_fill;
      if (leak_inject) raised[3] = 1'b1;
      if (motor_spin && old_level != 0) raised[1] = 1'b1;
      if (water_fill && drain) begin
        raised[0] = 1'b1;
      end else if (water_fill) begin
        if (old_level == LEVEL_MAX) raised[2] = 1'b1;
        nxt     = old_level + FILL_STEP;
        m_level = (nxt > LEVEL_MAX) ? LEVEL_MAX : nxt;
      end else begin
        nxt     = old_level - (drain ? DRAIN_STEP : 0) - (leak_now ? 1 : 0);
        m_level = (nxt < 0) ? 0 : nxt;
      end
      if (motor_wash && old_level != 0) m_moist = MOIST_MAX;
      else if (old_spin == 2 && old_level == 0 && m_moist > 0) m_moist = m_moist - 1;
      if (!motor_spin) m_spin_run = 0;
      else if (m_spin_run < 1000) m_spin_run = m_spin_run + 1;
    end
    m_err = (err_clr ? 4'b0000 : m_err) | raised;
  endtask

  task automatic checkVal(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".level"},      int'(level),      m_level);
    checkVal({tag, ".water_full"}, int'(water_full), (m_level >= FULL_LEVEL) ? 1 : 0);
    checkVal({tag, ".drained"},    int'(drained),    (m_level == 0) ? 1 : 0);
    checkVal({tag, ".dry_sensor"}, int'(dry_sensor), (m_moist == 0) ? 1 : 0);
    checkVal({tag, ".spin_state"}, int'(spin_state), spinExp(m_spin_run));
    checkVal({tag, ".err"},        int'(err),        int'(m_err));
  endtask

  task automatic doStep(input string tag);
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput(tag);
  endtask

  task automatic runSteps(input int n, input string tag);
    for (int i = 0; i < n; i++) doStep(tag);
  endtask

  initial begin
    int mode;
    bit se, wf, mw, ms, dr, ec, r;

    // Reset state
    applyStimulus(L, L, L, L, L, L, H);
    doStep("reset");
    checkVal("reset_level", int'(level), 0);
    checkVal("reset_drained", int'(drained), 1);
    checkVal("reset_dry", int'(dry_sensor), 1);
    checkVal("reset_full", int'(water_full), 0);
    checkVal("reset_spin", int'(spin_state), 0);
    checkVal("reset_err", int'(err), 0);

    // Fill up to the full threshold and on into saturation
    applyStimulus(H, H, L, L, L, L, L);
    runSteps(49, "fill");
    checkVal("fill49_level", int'(level), 196);
    checkVal("fill49_full", int'(water_full), 0);
    doStep("fill50");
    checkVal("fill50_level", int'(level), 200);
    checkVal("fill50_full", int'(water_full), 1);
    runSteps(14, "fill_sat");
    checkVal("fill64_level", int'(level), 255);
    checkVal("fill64_err", int'(err), 0);
    doStep("fill65");
    checkVal("fill65_level", int'(level), 255);
    checkVal("fill65_err", int'(err), 4'b0100);

    // Wash at 200, drain to empty, then spin dry
    applyStimulus(L, L, L, L, L, L, H);
    doStep("reset2");
    applyStimulus(H, H, L, L, L, L, L);
    runSteps(50, "fill_b");
    applyStimulus(H, L, H, L, L, L, L);
    doStep("wash");
    checkVal("wash_dry", int'(dry_sensor), 0);
    applyStimulus(H, L, L, L, H, L, L);
    runSteps(25, "drain");
    checkVal("drain25_level", int'(level), 0);
    checkVal("drain25_drained", int'(drained), 1);
    doStep("drain26");
    checkVal("drain26_level", int'(level), 0);
    checkVal("drain26_err", int'(err), 0);
    applyStimulus(H, L, L, H, L, L, L);
    for (int i = 0; i < SPINUP_STEPS; i++) begin
      doStep("ramp");
      checkVal("ramp_state", int'(spin_state), 1);
    end
    doStep("at_speed");
    checkVal("at_speed_state", int'(spin_state), 2);
    runSteps(15, "drying");
    checkVal("dry15", int'(dry_sensor), 0);
    doStep("dry16");
    checkVal("dry16", int'(dry_sensor), 1);

    // Drop spin part-way through drying: moisture must hold at 6
    applyStimulus(H, H, L, L, L, L, L);
    doStep("refill");
    applyStimulus(H, L, H, L, L, L, L);
    doStep("rewash");
    applyStimulus(H, L, L, L, H, L, L);
    doStep("redrain");
    applyStimulus(H, L, L, H, L, L, L);
    runSteps(SPINUP_STEPS + 1, "respin");
    checkVal("respin_state", int'(spin_state), 2);
    runSteps(9, "partdry");
    applyStimulus(H, L, L, L, L, L, L);
    doStep("spin_drop");
    checkVal("spin_drop_state", int'(spin_state), 0);
    checkVal("spin_drop_dry", int'(dry_sensor), 0);
    runSteps(3, "idle");
    applyStimulus(H, L, L, H, L, L, L);
    runSteps(SPINUP_STEPS + 1, "spin_again");
    runSteps(5, "finish_dry");
    checkVal("held6_after5", int'(dry_sensor), 0);
    doStep("held6_after6");
    checkVal("held6_after6", int'(dry_sensor), 1);

    // Fill/drain conflict and error clearing
    applyStimulus(L, L, L, L, L, L, H);
    doStep("reset3");
    applyStimulus(H, H, L, L, L, L, L);
    runSteps(25, "fill_c");
    applyStimulus(H, H, L, L, H, L, L);
    doStep("conflict");
    checkVal("conflict_level", int'(level), 100);
    checkVal("conflict_err", int'(err), 4'b0001);
    applyStimulus(L, L, L, L, L, H, L);
    doStep("clear");
    checkVal("clear_err", int'(err), 0);
    applyStimulus(H, L, L, H, L, L, L);
    doStep("spin_wet");
    checkVal("spin_wet_err", int'(err), 4'b0010);
    applyStimulus(H, H, L, L, H, H, L);
    doStep("clear_and_set");
    checkVal("clear_and_set_err", int'(err), 4'b0001);
    checkVal("clear_and_set_level", int'(level), 100);

    // Frozen model time with every command asserted
    applyStimulus(L, H, H, H, H, L, L);
    runSteps(20, "frozen");
    checkVal("frozen_level", int'(level), 100);
    checkVal("frozen_spin", int'(spin_state), 0);
    checkVal("frozen_err", int'(err), 4'b0001);

    // Reset in the middle of a fill with the drum ramping up
    applyStimulus(L, L, L, L, L, L, H);
    doStep("reset4");
    applyStimulus(H, H, L, L, L, L, L);
    runSteps(28, "fill_d");
    applyStimulus(H, H, L, H, L, L, L);
    runSteps(2, "fill_spin");
    checkVal("mid_level", int'(level), 120);
    checkVal("mid_spin", int'(spin_state), 1);
    checkVal("mid_err", int'(err), 4'b0010);
    applyStimulus(H, H, L, H, L, L, H);
    doStep("mid_reset");
    checkVal("mid_reset_level", int'(level), 0);
    checkVal("mid_reset_spin", int'(spin_state), 0);
    checkVal("mid_reset_err", int'(err), 0);
    checkVal("mid_reset_drained", int'(drained), 1);
    checkVal("mid_reset_dry", int'(dry_sensor), 1);

    // Random command bursts, each burst biased towards filling, draining+spinning or anything
    for (int b = 0; b < 40; b++) begin
      mode = int'($urandom_range(0, 2));
      for (int c = 0; c < 16; c++) begin
        se = ($urandom_range(0, 9) != 0);
        case (mode)
          0: begin
            wf = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 7) == 0);
            ms = ($urandom_range(0, 7) == 0);
            mw = ($urandom_range(0, 2) == 0);
          end
          1: begin
            wf = ($urandom_range(0, 9) == 0);
            dr = ($urandom_range(0, 3) != 0);
            ms = ($urandom_range(0, 5) != 0);
            mw = ($urandom_range(0, 9) == 0);
          end
          default: begin
            wf = ($urandom_range(0, 1) == 1);
            dr = ($urandom_range(0, 1) == 1);
            ms = ($urandom_range(0, 1) == 1);
            mw = ($urandom_range(0, 1) == 1);
          end
        endcase
        ec = ($urandom_range(0, 19) == 0);
        r  = ($urandom_range(0, 99) == 0);
        applyStimulus(se, wf, mw, ms, dr, ec, r);
`ifdef WASHER_PLANT_LEAK_EN
        leak_inject = ($urandom_range(0, 7) == 0);
`endif
        doStep("random");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
